// File: rtl/nand_unit_arbiter.sv
// nand_unit_arbiter: round-robin shared NAND-family logic unit.
// One op in flight; capture, evaluate, then hold response until taken.
module nand_unit_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    localparam logic [IDW:0]   N_WIDE = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] ID_MAX = IDW'(N_REQ - 1);

    state_t state, state_nxt;

    logic [IDW-1:0]   rr_ptr;
    logic [IDW:0]     cand;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [IDW-1:0]   cap_id;
    logic [2:0]       cap_op;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;

    logic [WIDTH-1:0] eval_data;
    logic             eval_err;

    logic             accept;
    logic             rsp_done;

    assign accept   = (state == S_IDLE) && win_found;
    assign rsp_done = (state == S_RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> EXEC on a grant, EXEC -> RESP, RESP -> IDLE on handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (win_found) state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_RESP;
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready only toward the winner while idle
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
        rsp_valid = (state == S_RESP);
        busy      = (state != S_IDLE);
    end

    // Round-robin search starting at rr_ptr, wrapping at N_REQ
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= N_WIDE) begin
                cand = cand - N_WIDE;
            end
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IDW-1:0];
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == win_id) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Capture the granted op so later input changes cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_id <= '0;
            cap_op <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
        end else if (accept) begin
            cap_id <= win_id;
            cap_op <= sel_op;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
        end
    end

    // Logic unit evaluated on the captured operands
    always_comb begin
        eval_data = '0;
        eval_err  = 1'b0;
        unique case (cap_op)
            OP_NAND: eval_data = ~(cap_a & cap_b);
            OP_AND:  eval_data = cap_a & cap_b;
            OP_OR:   eval_data = cap_a | cap_b;
            OP_NOR:  eval_data = ~(cap_a | cap_b);
            OP_XOR:  eval_data = cap_a ^ cap_b;
            OP_XNOR: eval_data = ~(cap_a ^ cap_b);
            OP_NOTA: eval_data = ~cap_a;
            default: eval_err  = 1'b1;
        endcase
    end

    // Response registers load in EXEC and hold through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_id   <= cap_id;
            rsp_data <= eval_data;
            rsp_err  <= eval_err;
        end
    end

    // Pointer moves past the requester whose response was just taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (rsp_done) begin
            rr_ptr <= (rsp_id == ID_MAX) ? '0 : rsp_id + 1'b1;
        end
    end

endmodule
